// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage.
//   word_t        : 32-bit machine word
//   opcode_t      : 6-bit primary opcode field (instr[31:26])
//   HALT          : opcode that stops fetching
//   fetch_state_t : fetch controller states
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [5:0]  opcode_t;

    localparam opcode_t HALT = 6'h3F;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        REDIR  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Redirect targets are word aligned; low two bits are dropped.
    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register.
//   CLK, nRST        : clock, synchronous active-low reset
//   load_i           : capture instr_i/npc_i as a valid instruction
//   bubble_i         : clear to an empty slot (instr 0, npc 0, valid 0)
//   instr_i, npc_i   : incoming instruction word and its PC+4
//   instr_o, npc_o   : latched instruction and PC+4
//   valid_o          : latched slot holds a real instruction
// With neither load_i nor bubble_i asserted the contents are held.
module if_id_latch
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  load_i,
    input  logic  bubble_i,
    input  word_t instr_i,
    input  word_t npc_i,
    output word_t instr_o,
    output word_t npc_o,
    output logic  valid_o
);

    word_t instr_q, instr_d;
    word_t npc_q, npc_d;
    logic  valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        if (load_i) begin
            instr_d = instr_i;
            npc_d   = npc_i;
            valid_d = 1'b1;
        end else if (bubble_i) begin
            instr_d = '0;
            npc_d   = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            instr_q <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign npc_o   = npc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, redirect handling and IF/ID register.
//   CLK, nRST          : clock, synchronous active-low reset
//   ihit, imemload     : instruction memory response for imemaddr
//   hazard, mem_stall  : freeze requests (either one holds everything)
//   branch/jump, *_target : redirects resolved in decode (jump wins)
//   imemREN, imemaddr  : instruction memory request
//   if_instr, if_npc, if_valid : IF/ID register outputs
//
// state  | meaning
// FETCH  | normal sequential fetch from PC
// REDIR  | redirect seen while a fetch was outstanding; finish the old
//        | request, discard its word, then jump to pend_pc
// HALTED | HALT accepted; no requests until a redirect arrives
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t imemload,
    input  logic  hazard,
    input  logic  mem_stall,
    input  logic  branch,
    input  word_t branch_target,
    input  logic  jump,
    input  word_t jump_target,
    output logic  imemREN,
    output word_t imemaddr,
    output word_t if_instr,
    output word_t if_npc,
    output logic  if_valid
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        pend_pc_q, pend_pc_d;

    logic  stall, redirect, load, bubble;
    word_t target, pc_plus4;

    assign stall    = hazard | mem_stall;
    assign redirect = (jump | branch) & ~stall;
    assign target   = align_word(jump ? jump_target : branch_target);
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        load      = 1'b0;
        bubble    = 1'b0;
        if (!stall) begin
            unique case (state_q)
                FETCH: begin
                    if (redirect) begin
                        bubble = 1'b1;
                        if (ihit) begin
                            pc_d = target;
                        end else begin
                            // The memory is still busy with pc_q; remember
                            // where to go once it answers.
                            pend_pc_d = target;
                            state_d   = REDIR;
                        end
                    end else if (ihit) begin
                        load = 1'b1;
                        pc_d = pc_plus4;
                        if (opcode_t'(imemload[31:26]) == HALT) begin
                            state_d = HALTED;
                        end
                    end else begin
                        bubble = 1'b1;
                    end
                end
                REDIR: begin
                    bubble = 1'b1;
                    if (redirect) begin
                        pend_pc_d = target;
                    end else if (ihit) begin
                        pc_d    = pend_pc_q;
                        state_d = FETCH;
                    end
                end
                HALTED: begin
                    bubble = 1'b1;
                    if (redirect) begin
                        pc_d    = target;
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= FETCH;
            pc_q      <= PC_INIT;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // In REDIR pc_q still holds the abandoned fetch address.
    assign imemaddr = pc_q;
    assign imemREN  = (state_q != HALTED);

    if_id_latch u_if_id (
        .CLK      (CLK),
        .nRST     (nRST),
        .load_i   (load),
        .bubble_i (bubble),
        .instr_i  (imemload),
        .npc_i    (pc_plus4),
        .instr_o  (if_instr),
        .npc_o    (if_npc),
        .valid_o  (if_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  ihit;
    word_t imemload;
    logic  hazard, mem_stall, branch, jump;
    word_t branch_target, jump_target;
    logic  imemREN;
    word_t imemaddr, if_instr, if_npc;
    logic  if_valid;

    int checks = 0;
    int fails  = 0;

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .ihit          (ihit),
        .imemload      (imemload),
        .hazard        (hazard),
        .mem_stall     (mem_stall),
        .branch        (branch),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imemREN       (imemREN),
        .imemaddr      (imemaddr),
        .if_instr      (if_instr),
        .if_npc        (if_npc),
        .if_valid      (if_valid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] npc,
                            input logic v);
        chk({tag, ".instr"}, if_instr, ins);
        chk({tag, ".npc"}, if_npc, npc);
        chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
    endtask

    task automatic chk_req(input string tag, input logic [31:0] addr, input logic ren);
        chk({tag, ".addr"}, imemaddr, addr);
        chk({tag, ".ren"}, {31'd0, imemREN}, {31'd0, ren});
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b0; imemload = '0; hazard = 1'b0; mem_stall = 1'b0;
        branch = 1'b0; jump = 1'b0; branch_target = '0; jump_target = '0;

        // Reset
        tick();
        chk_req("rst", 32'h0, 1'b1);
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);

        // Sequential fetch
        nRST = 1'b1; ihit = 1'b1; imemload = 32'h2001_0005;
        tick();
        chk_req("seq1", 32'h4, 1'b1);
        chk_ifid("seq1", 32'h2001_0005, 32'h4, 1'b1);
        tick();
        chk_req("seq2", 32'h8, 1'b1);
        chk_ifid("seq2", 32'h2001_0005, 32'h8, 1'b1);
        tick();
        chk_req("seq3", 32'hC, 1'b1);
        chk("seq3.npc", if_npc, 32'hC);
        tick();
        chk_req("seq4", 32'h10, 1'b1);

        // Hazard stall for two cycles, then mem_stall masking a branch
        hazard = 1'b1; imemload = 32'h1111_1111;
        tick();
        chk_req("haz1", 32'h10, 1'b1);
        chk_ifid("haz1", 32'h2001_0005, 32'h10, 1'b1);
        tick();
        chk_req("haz2", 32'h10, 1'b1);
        chk_ifid("haz2", 32'h2001_0005, 32'h10, 1'b1);
        hazard = 1'b0; mem_stall = 1'b1; branch = 1'b1; branch_target = 32'h80;
        tick();
        chk_req("mstall", 32'h10, 1'b1);
        chk("mstall.npc", if_npc, 32'h10);
        mem_stall = 1'b0; branch = 1'b0;
        tick();
        chk_req("unstall", 32'h14, 1'b1);
        chk_ifid("unstall", 32'h1111_1111, 32'h14, 1'b1);

        // Advance to 0x20, then jump+branch together (jump wins, low bits dropped)
        tick(); tick(); tick();
        chk_req("to20", 32'h20, 1'b1);
        branch = 1'b1; jump = 1'b1; branch_target = 32'h80; jump_target = 32'h41;
        tick();
        chk_req("jprio", 32'h40, 1'b1);
        chk_ifid("jprio", 32'h0, 32'h0, 1'b0);
        branch = 1'b0; jump = 1'b0;

        // Miss without redirect: bubble, PC held
        ihit = 1'b0;
        tick();
        chk_req("miss", 32'h40, 1'b1);
        chk("miss.valid", {31'd0, if_valid}, 32'd0);

        // Branch alone with hit
        ihit = 1'b1; branch = 1'b1; branch_target = 32'h30;
        tick();
        chk_req("br", 32'h30, 1'b1);
        chk("br.valid", {31'd0, if_valid}, 32'd0);
        branch = 1'b0;

        // Redirect while fetch outstanding -> REDIR
        ihit = 1'b0; jump = 1'b1; jump_target = 32'h100;
        tick();
        chk_req("redir1", 32'h30, 1'b1);
        chk("redir1.valid", {31'd0, if_valid}, 32'd0);
        jump = 1'b0;
        tick();
        chk_req("redir2", 32'h30, 1'b1);
        // Overwrite pending target twice; final one uses jump priority
        branch = 1'b1; branch_target = 32'h180;
        tick();
        chk_req("redir3", 32'h30, 1'b1);
        jump = 1'b1; jump_target = 32'h100;
        tick();
        chk_req("redir4", 32'h30, 1'b1);
        jump = 1'b0; branch = 1'b0; ihit = 1'b1; imemload = 32'hDEAD_BEEF;
        tick();
        chk_req("redir_done", 32'h100, 1'b1);
        chk_ifid("redir_done", 32'h0, 32'h0, 1'b0);
        imemload = 32'h2001_0005;
        tick();
        chk_req("after_redir", 32'h104, 1'b1);
        chk_ifid("after_redir", 32'h2001_0005, 32'h104, 1'b1);

        // HALT at 0x8
        jump = 1'b1; jump_target = 32'h8;
        tick();
        chk_req("to8", 32'h8, 1'b1);
        jump = 1'b0; imemload = 32'hFC00_0000;
        tick();
        chk_req("halt", 32'hC, 1'b0);
        chk_ifid("halt", 32'hFC00_0000, 32'hC, 1'b1);
        tick();
        chk_req("halted", 32'hC, 1'b0);
        chk_ifid("halted", 32'h0, 32'h0, 1'b0);
        hazard = 1'b1; branch = 1'b1; branch_target = 32'h44;
        tick();
        chk_req("halt_stall", 32'hC, 1'b0);
        hazard = 1'b0;
        tick();
        chk_req("unhalt", 32'h44, 1'b1);
        chk("unhalt.valid", {31'd0, if_valid}, 32'd0);
        branch = 1'b0;

        // Reset from REDIR
        ihit = 1'b0; jump = 1'b1; jump_target = 32'h200;
        tick();
        chk_req("redir_pre_rst", 32'h44, 1'b1);
        jump = 1'b0; nRST = 1'b0; ihit = 1'b1;
        tick();
        chk_req("rst_redir", 32'h0, 1'b1);
        chk_ifid("rst_redir", 32'h0, 32'h0, 1'b0);
        nRST = 1'b1; imemload = 32'h2001_0005;
        tick();
        chk_req("post_rst", 32'h4, 1'b1);
        chk("post_rst.valid", {31'd0, if_valid}, 32'd1);

        // PC wraps modulo 2^32
        jump = 1'b1; jump_target = 32'hFFFF_FFFF;
        tick();
        chk_req("wrap_pre", 32'hFFFF_FFFC, 1'b1);
        jump = 1'b0;
        tick();
        chk_req("wrap", 32'h0, 1'b1);
        chk_ifid("wrap", 32'h2001_0005, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0000_0000, meaning PC value after reset.
REQ-002 SHALL have port CLK input 1 system clock; one clock domain only.
REQ-003 SHALL have port nRST input 1 reset, synchronous, active-low.
REQ-004 SHALL have port ihit input 1 instruction memory returned imemload for imemaddr this cycle.
REQ-005 SHALL have port imemload input 32 (word_t) fetched instruction word.
REQ-006 SHALL have port hazard input 1 decode stall request from the hazard unit.
REQ-007 SHALL have port mem_stall input 1 data-memory-side pipeline freeze.
REQ-008 SHALL have port branch input 1 taken conditional branch resolved in decode.
REQ-009 SHALL have port branch_target input 32 branch destination.
REQ-010 SHALL have port jump input 1 J/JAL/JR resolved in decode.
REQ-011 SHALL have port jump_target input 32 jump destination.
REQ-012 SHALL have port imemREN output 1 instruction read enable.
REQ-013 SHALL have port imemaddr output 32 fetch address.
REQ-014 SHALL have port if_instr output 32 IF/ID latched instruction.
REQ-015 SHALL have port if_npc output 32 IF/ID latched PC+4.
REQ-016 SHALL have port if_valid output 1 IF/ID holds a real instruction.

Function
REQ-017 SHALL define stall = hazard | mem_stall; redirect = (jump | branch) & !stall; jump takes priority over branch; bits [1:0] of the selected target forced to 0.
REQ-018 SHALL implement states FETCH, REDIR, HALTED.
REQ-019 SHALL drive imemaddr = PC in FETCH and HALTED, and the PC of the abandoned fetch in REDIR; imemREN = 1 in FETCH/REDIR, 0 in HALTED.
REQ-020 In FETCH with ihit & !stall & !redirect, SHALL at the next edge set PC <= PC+4 (mod 2^32), if_instr <= imemload, if_npc <= PC+4, if_valid <= 1.
REQ-021 In FETCH with !ihit & !stall & !redirect, SHALL hold PC and load a bubble (if_instr 0, if_npc 0, if_valid 0).
REQ-022 With stall (any state), SHALL hold PC, IF/ID and state unchanged; branch/jump ignored.
REQ-023 In FETCH with redirect & ihit, SHALL set PC <= target and load a bubble; the returned word is discarded.
REQ-024 In FETCH with redirect & !ihit, SHALL latch target into pend_pc, load a bubble, enter REDIR; PC unchanged.
REQ-025 In REDIR, SHALL keep requesting old PC; on ihit discard the word, set PC <= pend_pc, enter FETCH; a new redirect in REDIR overwrites pend_pc (jump priority holds) and stays in REDIR; bubbles inserted each non-stalled cycle.
REQ-026 In FETCH, if accepted word (REQ-020) has opcode HALT (bits[31:26] = 6'h3F), SHALL latch it and enter HALTED; PC advances to PC+4.
REQ-027 In HALTED, SHALL insert bubbles each non-stalled cycle; redirect SHALL set PC <= target, load a bubble and return to FETCH (halt was wrong-path).
REQ-028 SHALL never assert if_valid with a discarded or wrong-path word.

Reset
REQ-029 On CLK edge with nRST = 0, SHALL set PC <= PC_INIT, pend_pc <= 0, state <= FETCH, if_instr <= 0, if_npc <= 0, if_valid <= 0; reset overrides all inputs, including mid-REDIR or HALTED.
REQ-030 First cycle after reset SHALL present imemREN = 1, imemaddr = PC_INIT.

Structure
REQ-031 word_t, opcode_t and HALT SHALL come from cpu_types_pkg; fetch_state_t enum (FETCH, REDIR, HALTED) SHALL be added to cpu_types_pkg.
REQ-032 The IF/ID register (load/bubble/hold control) SHALL be a sub-module named if_id_latch; PC, pend_pc and FSM stay in fetch_stage.

Verification
REQ-033 Reset then ihit=1 every cycle, imemload=32'h2001_0005 -> imemaddr 0,4,8; if_npc 4,8,12; if_valid=1 from second edge.
REQ-034 PC=0x10, ihit=1, hazard=1 for 2 cycles -> imemaddr stays 0x10, IF/ID unchanged; hazard drops -> PC 0x14.
REQ-035 PC=0x20, ihit=1, branch=1, jump=1, branch_target=0x80, jump_target=0x40 -> PC=0x40, if_valid=0.
REQ-036 PC=0x30, ihit=0, jump=1, jump_target=0x100 -> REDIR, imemaddr 0x30 until ihit; next edge PC=0x100, state FETCH, no valid word from 0x30.
REQ-037 imemload=32'hFC00_0000 at PC=0x8 -> HALTED, imemREN=0, bubbles; then branch=1, target=0x44 -> FETCH, PC=0x44.
REQ-038 nRST=0 while in REDIR with pend_pc=0x200 -> next edge PC=PC_INIT, state FETCH, if_valid=0, pend_pc=0.
